wb_flash_arbiter: RTL and testbench

Two-master round-robin Wishbone arbiter that shares the single wb_flash_anvylsword slave port between requesters, e.g. CPU instruction fetch (m0) and a DMA/boot-copy engine (m1).
- Sits on clk_bus directly in front of the flash slave.
- Grant is locked for the whole cycle, so burst and multi-beat transfers are never split.
- A watchdog aborts any transfer the slave never acknowledges, so a stalled flash cannot hang the bus.

---
 rtl/wb_flash_arbiter_pkg.sv | 26 ++
 rtl/wb_watchdog.sv | 41 ++++
 rtl/wb_flash_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_wb_flash_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_flash_arbiter_pkg.sv
// Shared definitions for the two-master flash arbiter.
// Holds the arbiter state encoding, the Wishbone CTI constants and a small
// helper that maps an arbiter state to its one-hot grant vector.
package wb_flash_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN0  = 2'd1,
    ARB_OWN1  = 2'd2,
    ARB_ABORT = 2'd3
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // One-hot owner; ABORT and IDLE both report no owner.
  function automatic logic [1:0] grant_of(input arb_state_t s);
    logic [1:0] g;
    g = 2'b00;
    if (s == ARB_OWN0) g = 2'b01;
    if (s == ARB_OWN1) g = 2'b10;
    return g;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Purpose: counts stalled stb cycles and flags a transfer the slave never acks.
// Latency: expire_o is combinational, high in the cycle whose edge would bring
//   the count to TIMEOUT-1; clr_i has priority over en_i.
// Ports: clk_bus/rst, clr_i (zero the count), en_i (count this cycle), expire_o.
module wb_watchdog #(
  parameter int TIMEOUT = 1024,
  parameter int TO_BITS = 16
) (
  input  logic clk_bus,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TO_BITS-1:0] LAST_OK = TO_BITS'(TIMEOUT - 2);

  logic [TO_BITS-1:0] cnt_q;
  logic [TO_BITS-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TO_BITS'(1);
    end
  end

  // An ack in the same cycle arrives through clr_i and suppresses the expiry.
  assign expire_o = en_i & ~clr_i & (cnt_q == LAST_OK);

  always_ff @(posedge clk_bus) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_flash_arbiter.sv
// Purpose: two-master round-robin Wishbone arbiter in front of the flash slave.
// Latency: grant registered one edge after cyc is sampled; data/ack/err paths are
//   combinational while owned; grant is held for the whole cyc (bursts never split).
// Backpressure: the non-owner simply sees no ack; a stalled slave is cut off by the
//   watchdog, which answers the owner with a one-cycle err and sets timeout_flag.
// Ports: m0_*/m1_* master sides, s_* slave side, grant (one-hot owner),
//   timeout_flag (sticky abort indicator).
module wb_flash_arbiter
  import wb_flash_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 1024,
  parameter int TO_BITS    = 16
) (
  input  logic                  clk_bus,
  input  logic                  rst,

  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [2:0]            m0_cti_i,
  input  logic [1:0]            m0_bte_i,
  input  logic [3:0]            m0_sel_i,
  input  logic [31:0]           m0_data_i,
  output logic [31:0]           m0_data_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,

  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [2:0]            m1_cti_i,
  input  logic [1:0]            m1_bte_i,
  input  logic [3:0]            m1_sel_i,
  input  logic [31:0]           m1_data_i,
  output logic [31:0]           m1_data_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,

  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [2:0]            s_cti_o,
  output logic [1:0]            s_bte_o,
  output logic [3:0]            s_sel_o,
  output logic [31:0]           s_data_o,
  input  logic [31:0]           s_data_i,
  input  logic                  s_ack_i,

  output logic [1:0]            grant,
  output logic                  timeout_flag
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;         // master served most recently
  logic       abort_own_q, abort_own_d; // master whose transfer was aborted
  logic       err_q, err_d;           // one-cycle err, valid in first ABORT cycle
  logic       tflag_q, tflag_d;

  logic       owning;
  logic       own_cyc;
  logic       own_stb;
  logic       wd_clr;
  logic       wd_en;
  logic       wd_expire;

  assign owning  = (state_q == ARB_OWN0) || (state_q == ARB_OWN1);
  assign own_cyc = (state_q == ARB_OWN0) ? m0_cyc_i :
                   (state_q == ARB_OWN1) ? m1_cyc_i : 1'b0;
  assign own_stb = (state_q == ARB_OWN0) ? m0_stb_i :
                   (state_q == ARB_OWN1) ? m1_stb_i : 1'b0;

  // Every path into OWNn passes through IDLE, so holding the counter clear
  // outside OWNn also clears it on state entry.
  assign wd_clr = ~owning | s_ack_i;
  assign wd_en  = owning & own_cyc & own_stb & ~s_ack_i;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_BITS (TO_BITS)
  ) u_watchdog (
    .clk_bus  (clk_bus),
    .rst      (rst),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    abort_own_d = abort_own_q;
    err_d       = 1'b0;
    tflag_d     = tflag_q;
    case (state_q)
      ARB_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          // Tie: the master that was not served last wins.
          if (last_q) begin
            state_d = ARB_OWN0;
            last_d  = 1'b0;
          end else begin
            state_d = ARB_OWN1;
            last_d  = 1'b1;
          end
        end else if (m0_cyc_i) begin
          state_d = ARB_OWN0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = ARB_OWN1;
          last_d  = 1'b1;
        end
      end
      ARB_OWN0: begin
        if (!m0_cyc_i) begin
          state_d = ARB_IDLE;
        end else if (wd_expire) begin
          state_d     = ARB_ABORT;
          abort_own_d = 1'b0;
          err_d       = 1'b1;
          tflag_d     = 1'b1;
        end
      end
      ARB_OWN1: begin
        if (!m1_cyc_i) begin
          state_d = ARB_IDLE;
        end else if (wd_expire) begin
          state_d     = ARB_ABORT;
          abort_own_d = 1'b1;
          err_d       = 1'b1;
          tflag_d     = 1'b1;
        end
      end
      ARB_ABORT: begin
        if (!(abort_own_q ? m1_cyc_i : m0_cyc_i)) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Output mux: the owner's controls go straight to the slave and the slave's
  // ack/data go straight back; everything else reads as zero.
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_cti_o   = 3'b000;
    s_bte_o   = 2'b00;
    s_sel_o   = 4'b0000;
    s_data_o  = 32'h0;
    m0_ack_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m0_data_o = 32'h0;
    m1_data_o = 32'h0;
    case (state_q)
      ARB_OWN0: begin
        s_cyc_o   = m0_cyc_i;
        s_stb_o   = m0_stb_i;
        s_we_o    = m0_we_i;
        s_addr_o  = m0_addr_i;
        s_cti_o   = m0_cti_i;
        s_bte_o   = m0_bte_i;
        s_sel_o   = m0_sel_i;
        s_data_o  = m0_data_i;
        m0_ack_o  = s_ack_i;
        m0_data_o = s_data_i;
      end
      ARB_OWN1: begin
        s_cyc_o   = m1_cyc_i;
        s_stb_o   = m1_stb_i;
        s_we_o    = m1_we_i;
        s_addr_o  = m1_addr_i;
        s_cti_o   = m1_cti_i;
        s_bte_o   = m1_bte_i;
        s_sel_o   = m1_sel_i;
        s_data_o  = m1_data_i;
        m1_ack_o  = s_ack_i;
        m1_data_o = s_data_i;
      end
      default: ;
    endcase
  end

  assign m0_err_o     = err_q & ~abort_own_q;
  assign m1_err_o     = err_q &  abort_own_q;
  assign grant        = grant_of(state_q);
  assign timeout_flag = tflag_q;

  always_ff @(posedge clk_bus) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      last_q      <= 1'b1;
      abort_own_q <= 1'b0;
      err_q       <= 1'b0;
      tflag_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      abort_own_q <= abort_own_d;
      err_q       <= err_d;
      tflag_q     <= tflag_d;
    end
  end

endmodule

// File: tb/tb_wb_flash_arbiter.sv
// Bench for wb_flash_arbiter with TIMEOUT=8: a cycle table for round-robin
// and watchdog abort, followed by hand sequences for reset, read data,
// ack at the watchdog limit and burst lock.
module tb_wb_flash_arbiter;
  import wb_flash_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk_bus = 1'b0;
  logic          rst;
  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic [AW-1:0] m0_addr_i;
  logic [2:0]    m0_cti_i;
  logic [1:0]    m0_bte_i;
  logic [3:0]    m0_sel_i;
  logic [31:0]   m0_data_i, m0_data_o;
  logic          m0_ack_o, m0_err_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m1_addr_i;
  logic [2:0]    m1_cti_i;
  logic [1:0]    m1_bte_i;
  logic [3:0]    m1_sel_i;
  logic [31:0]   m1_data_i, m1_data_o;
  logic          m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_addr_o;
  logic [2:0]    s_cti_o;
  logic [1:0]    s_bte_o;
  logic [3:0]    s_sel_o;
  logic [31:0]   s_data_o, s_data_i;
  logic          s_ack_i;
  logic [1:0]    grant;
  logic          timeout_flag;

  always #5 clk_bus = ~clk_bus;

  wb_flash_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TO), .TO_BITS(16)) dut (
    .clk_bus(clk_bus), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_addr_i(m0_addr_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
    .m0_sel_i(m0_sel_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_addr_i(m1_addr_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
    .m1_sel_i(m1_sel_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_sel_o(s_sel_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
    .s_ack_i(s_ack_i), .grant(grant), .timeout_flag(timeout_flag)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Drive just after the rising edge, sample mid-cycle before the falling edge.
  task automatic next();
    @(posedge clk_bus);
    #1;
  endtask

  task automatic sample();
    #3;
  endtask

  // in  = {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack}
  // out = {s_cyc, m0_ack, m1_ack, m0_err, m1_err, timeout_flag}
  typedef struct packed {
    logic [4:0] in;
    logic [1:0] gnt;
    logic [5:0] out;
  } vec_t;

  vec_t vt[26];

  initial begin
    int   acks;
    logic err_seen;
    logic [2:0] cti_v;

    // Round-robin: four rounds from a reset tie, one dead cycle between owners.
    vt[0]  = '{5'b11110, 2'b00, 6'b000000};
    vt[1]  = '{5'b11111, 2'b01, 6'b110000};
    vt[2]  = '{5'b00110, 2'b01, 6'b000000};
    vt[3]  = '{5'b11110, 2'b00, 6'b000000};
    vt[4]  = '{5'b11111, 2'b10, 6'b101000};
    vt[5]  = '{5'b11000, 2'b10, 6'b000000};
    vt[6]  = '{5'b11110, 2'b00, 6'b000000};
    vt[7]  = '{5'b11111, 2'b01, 6'b110000};
    vt[8]  = '{5'b00110, 2'b01, 6'b000000};
    vt[9]  = '{5'b11110, 2'b00, 6'b000000};
    vt[10] = '{5'b11111, 2'b10, 6'b101000};
    vt[11] = '{5'b11000, 2'b10, 6'b000000};
    vt[12] = '{5'b00000, 2'b00, 6'b000000};
    // Timeout: m0 stb raised at row 13, never acked; err at row 21 (8 cycles later).
    vt[13] = '{5'b11110, 2'b00, 6'b000000};
    for (int i = 14; i <= 20; i++) vt[i] = '{5'b11110, 2'b01, 6'b100000};
    vt[21] = '{5'b11110, 2'b00, 6'b000101};
    vt[22] = '{5'b11111, 2'b00, 6'b000001}; // stray ack during abort not forwarded
    vt[23] = '{5'b00110, 2'b00, 6'b000001};
    vt[24] = '{5'b00110, 2'b00, 6'b000001};
    vt[25] = '{5'b00110, 2'b10, 6'b100001};

    rst = 1'b1;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_addr_i = 32'h0000_0044;
    m0_cti_i = CTI_CLASSIC; m0_bte_i = 2'b00; m0_sel_i = 4'hF; m0_data_i = 32'hAAAA_5555;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_addr_i = 32'h0000_0088;
    m1_cti_i = CTI_CLASSIC; m1_bte_i = 2'b01; m1_sel_i = 4'h3; m1_data_i = 32'h1234_0000;
    s_ack_i = 0; s_data_i = 32'hCAFE_F00D;

    repeat (2) @(posedge clk_bus);
    #1;
    sample();
    check("rst.s_cyc", 32'(s_cyc_o), 0);
    check("rst.s_stb", 32'(s_stb_o), 0);
    check("rst.s_addr", s_addr_o, 0);
    check("rst.s_data", s_data_o, 0);
    check("rst.s_sel", 32'(s_sel_o), 0);
    check("rst.s_bte", 32'(s_bte_o), 0);
    check("rst.grant", 32'(grant), 0);
    check("rst.acks", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 0);
    check("rst.m0_data", m0_data_o, 0);
    check("rst.m1_data", m1_data_o, 0);
    check("rst.tflag", 32'(timeout_flag), 0);
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      next();
      {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_ack_i} = vt[i].in;
      sample();
      check($sformatf("vec%0d.grant", i), 32'(grant), 32'(vt[i].gnt));
      check($sformatf("vec%0d.s_cyc", i), 32'(s_cyc_o), 32'(vt[i].out[5]));
      check($sformatf("vec%0d.m0_ack", i), 32'(m0_ack_o), 32'(vt[i].out[4]));
      check($sformatf("vec%0d.m1_ack", i), 32'(m1_ack_o), 32'(vt[i].out[3]));
      check($sformatf("vec%0d.m0_err", i), 32'(m0_err_o), 32'(vt[i].out[2]));
      check($sformatf("vec%0d.m1_err", i), 32'(m1_err_o), 32'(vt[i].out[1]));
      check($sformatf("vec%0d.tflag", i), 32'(timeout_flag), 32'(vt[i].out[0]));
    end

    // Reset during an OWN1 wait state; m0 also requesting.
    next();
    rst = 1'b1; m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 0;
    sample();
    next();
    rst = 1'b0;
    sample();
    check("rmid.s_cyc", 32'(s_cyc_o), 0);
    check("rmid.grant", 32'(grant), 0);
    check("rmid.ack_err", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 0);
    check("rmid.tflag", 32'(timeout_flag), 0);
    next();
    m1_cyc_i = 0; m1_stb_i = 0;
    sample();
    check("rmid.m0_first", 32'(grant), 32'b01);
    next();
    m0_cyc_i = 0; m0_stb_i = 0;
    sample();
    next();
    sample();
    check("rmid.idle", 32'(grant), 0);

    // Single read by m0, slave acks in the third granted cycle.
    next();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_addr_i = 32'h10; m0_cti_i = CTI_CLASSIC;
    sample();
    check("rd.no_comb_grant", 32'(grant), 0);
    check("rd.no_comb_cyc", 32'(s_cyc_o), 0);
    next();
    sample();
    check("rd.grant", 32'(grant), 32'b01);
    check("rd.s_stb", 32'({s_cyc_o, s_stb_o}), 32'b11);
    check("rd.s_addr", s_addr_o, 32'h10);
    check("rd.early_ack", 32'(m0_ack_o), 0);
    next();
    sample();
    next();
    s_ack_i = 1; s_data_i = 32'hDEAD_BEEF;
    sample();
    check("rd.m0_ack", 32'(m0_ack_o), 1);
    check("rd.m0_data", m0_data_o, 32'hDEAD_BEEF);
    check("rd.m1_ack", 32'(m1_ack_o), 0);
    check("rd.m1_data", m1_data_o, 0);
    next();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    sample();
    next();
    sample();
    check("rd.release", 32'(grant), 0);

    // m1 read acked on the last cycle before the watchdog would fire.
    next();
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h20;
    sample();
    err_seen = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      next();
      s_ack_i = (i == 7);
      s_data_i = 32'h1234_5678;
      sample();
      err_seen = err_seen | m0_err_o | m1_err_o;
    end
    check("lim.m1_ack", 32'(m1_ack_o), 1);
    check("lim.m1_data", m1_data_o, 32'h1234_5678);
    next();
    s_ack_i = 0;
    sample();
    err_seen = err_seen | m0_err_o | m1_err_o;
    check("lim.still_owned", 32'({grant, s_cyc_o}), 32'b101);
    next();
    m1_cyc_i = 0; m1_stb_i = 0;
    sample();
    err_seen = err_seen | m0_err_o | m1_err_o;
    next();
    sample();
    check("lim.no_err", 32'(err_seen), 0);
    check("lim.tflag", 32'(timeout_flag), 0);

    // 4-beat incrementing burst by m1; m0 requests after the first beat.
    next();
    m1_cyc_i = 1; m1_stb_i = 1; m1_cti_i = CTI_INCR; m1_addr_i = 32'h100;
    sample();
    acks = 0;
    for (int i = 1; i <= 4; i++) begin
      next();
      s_ack_i = 1;
      m1_addr_i = 32'h100 + 32'(4 * (i - 1));
      cti_v = (i == 4) ? CTI_EOB : CTI_INCR;
      m1_cti_i = cti_v;
      if (i == 1) begin m0_cyc_i = 1; m0_stb_i = 1; end
      sample();
      if (m1_ack_o) acks++;
      check($sformatf("bst%0d.grant", i), 32'(grant), 32'b10);
      check($sformatf("bst%0d.m0_ack", i), 32'(m0_ack_o), 0);
      check($sformatf("bst%0d.cti", i), 32'(s_cti_o), 32'(cti_v));
      check($sformatf("bst%0d.addr", i), s_addr_o, 32'h100 + 32'(4 * (i - 1)));
    end
    check("bst.acks", 32'(acks), 4);
    next();
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    sample();
    check("bst.held", 32'(grant), 32'b10);
    next();
    sample();
    check("bst.dead", 32'(grant), 0);
    next();
    sample();
    check("bst.m0_next", 32'(grant), 32'b01);
    next();
    m0_cyc_i = 0; m0_stb_i = 0;
    sample();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
